// File: rtl/keystream_xor_if.sv
// Stream bundle for keystream_xor: keystream beats in, data words in, XORed words out.
// The slave modport is the block's view; master is the surrounding logic's view.
interface keystream_xor_if #(
  parameter int UNROLL = 9,
  parameter int DEPTH  = 4
);
  logic [32*UNROLL-1:0]        KS_IN;
  logic                        KS_VLD;
  logic                        KS_RDY;
  logic [31:0]                 DIN;
  logic                        DIN_VLD;
  logic                        DIN_RDY;
  logic [31:0]                 DOUT;
  logic                        DOUT_VLD;
  logic                        DOUT_RDY;
  logic [$clog2(DEPTH+1)-1:0]  LEVEL;
  logic [15:0]                 WCNT;

  modport slave (
    input  KS_IN, KS_VLD, DIN, DIN_VLD, DOUT_RDY,
    output KS_RDY, DIN_RDY, DOUT, DOUT_VLD, LEVEL, WCNT
  );

  modport master (
    output KS_IN, KS_VLD, DIN, DIN_VLD, DOUT_RDY,
    input  KS_RDY, DIN_RDY, DOUT, DOUT_VLD, LEVEL, WCNT
  );
endinterface

// File: rtl/keystream_xor.sv
// Buffers keystream beats in a DEPTH-entry FIFO and XORs data words with them, word 0 first.
// DIN -> DOUT is one registered cycle; a stalled sink or empty FIFO drops DIN_RDY, full FIFO drops KS_RDY.
module keystream_xor #(
  parameter int UNROLL = 9,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CLR,
  keystream_xor_if.slave    bus
);
  localparam int WW = 32 * UNROLL;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (UNROLL > 1) ? $clog2(UNROLL) : 1;

  logic [WW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_dout;
  logic          r_dout_vld;
  logic [15:0]   r_wcnt;

  logic          w_ks_rdy;
  logic          w_din_rdy;
  logic          w_push;
  logic          w_fire;
  logic          w_last;
  logic          w_pop;
  logic [WW-1:0] w_head;
  logic [31:0]   w_ks_word;

  // Ready is a pure function of registered occupancy; a same-cycle pop never frees a slot early.
  assign w_ks_rdy  = (r_level != LW'(DEPTH));
  assign w_din_rdy = (r_level != '0) && (!r_dout_vld || bus.DOUT_RDY);
  assign w_push    = bus.KS_VLD && w_ks_rdy;
  assign w_fire    = bus.DIN_VLD && w_din_rdy;
  assign w_last    = (r_idx == IW'(UNROLL - 1));
  assign w_pop     = w_fire && w_last;
  assign w_head    = r_mem[r_rptr];

  // Word 0 sits in the most significant lane of the beat.
  always_comb begin
    w_ks_word = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (r_idx == IW'(i)) begin
        w_ks_word = w_head[WW-32-32*i +: 32];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTn && !CLR && w_push) begin
      r_mem[r_wptr] <= bus.KS_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_idx      <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_wcnt     <= '0;
    end else if (CLR) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_idx      <= '0;
      r_dout_vld <= 1'b0;
      r_wcnt     <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_fire) begin
        r_dout     <= bus.DIN ^ w_ks_word;
        r_dout_vld <= 1'b1;
        r_wcnt     <= r_wcnt + 16'd1;
        r_idx      <= w_last ? '0 : r_idx + 1'b1;
      end else if (bus.DOUT_RDY) begin
        r_dout_vld <= 1'b0;
      end
    end
  end

  assign bus.KS_RDY   = w_ks_rdy;
  assign bus.DIN_RDY  = w_din_rdy;
  assign bus.DOUT     = r_dout;
  assign bus.DOUT_VLD = r_dout_vld;
  assign bus.LEVEL    = r_level;
  assign bus.WCNT     = r_wcnt;
endmodule

// File: tb/tb_keystream_xor.sv
// Bench for keystream_xor: the reference treats buffered keystream as one flat word queue.
module tb_keystream_xor;
  localparam int UNROLL = 9;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int WW     = 32 * UNROLL;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic clr  = 1'b0;
  always #5 clk = ~clk;

  keystream_xor_if #(.UNROLL(UNROLL), .DEPTH(DEPTH)) bus();

  keystream_xor #(.UNROLL(UNROLL), .DEPTH(DEPTH)) dut (
    .CLK  (clk),
    .RSTn (rstn),
    .CLR  (clr),
    .bus  (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ks_q[$];
  logic [31:0] m_dout;
  logic        m_vld;
  logic [15:0] m_wcnt;
  int          m_hs;

  function automatic int f_level();
    return (ks_q.size() + UNROLL - 1) / UNROLL;
  endfunction

  function automatic logic f_ks_rdy();
    return f_level() != DEPTH;
  endfunction

  function automatic logic f_din_rdy();
    return (f_level() != 0) && (!m_vld || bus.DOUT_RDY);
  endfunction

  function automatic logic [31:0] word_of(input logic [WW-1:0] b, input int j);
    return b[32*(UNROLL-1-j) +: 32];
  endfunction

  function automatic logic [WW-1:0] rand_beat();
    logic [WW-1:0] b;
    for (int j = 0; j < UNROLL; j++) b[32*j +: 32] = $urandom;
    return b;
  endfunction

  // Advance the reference by one edge using the currently driven inputs, then let the edge happen.
  task automatic tick();
    logic krdy, drdy, fire;
    krdy = f_ks_rdy();
    drdy = f_din_rdy();
    fire = bus.DIN_VLD && drdy;
    if (!rstn) begin
      ks_q.delete(); m_dout = '0; m_vld = 1'b0; m_wcnt = '0;
    end else if (clr) begin
      ks_q.delete(); m_vld = 1'b0; m_wcnt = '0;
    end else begin
      if (m_vld && bus.DOUT_RDY) m_hs++;
      if (fire) begin
        m_dout = bus.DIN ^ ks_q.pop_front();
        m_vld  = 1'b1;
        m_wcnt = m_wcnt + 16'd1;
      end else if (bus.DOUT_RDY) begin
        m_vld = 1'b0;
      end
      if (bus.KS_VLD && krdy) begin
        for (int j = 0; j < UNROLL; j++) ks_q.push_back(word_of(bus.KS_IN, j));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; clr = 1'b0;
    bus.KS_IN = '0; bus.KS_VLD = 1'b0; bus.DIN = '0; bus.DIN_VLD = 1'b0; bus.DOUT_RDY = 1'b0;
    m_hs = 0;
    tick(); tick();
    checks++; if (bus.DOUT !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.DOUT); end
    checks++; if (bus.DOUT_VLD !== 1'b0) begin failures++; $display("FAIL reset_dout_vld got=%b exp=0", bus.DOUT_VLD); end
    checks++; if (bus.DIN_RDY !== 1'b0) begin failures++; $display("FAIL reset_din_rdy got=%b exp=0", bus.DIN_RDY); end
    checks++; if (bus.KS_RDY !== 1'b1) begin failures++; $display("FAIL reset_ks_rdy got=%b exp=1", bus.KS_RDY); end
    checks++; if (bus.LEVEL !== LW'(0)) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.LEVEL); end
    checks++; if (bus.WCNT !== 16'h0) begin failures++; $display("FAIL reset_wcnt got=%0d exp=0", bus.WCNT); end
  endtask

  task automatic test_xor_order();
    logic [WW-1:0] b;
    logic [31:0]   exp;
    rstn = 1'b1;
    for (int j = 0; j < UNROLL; j++) b[32*(UNROLL-1-j) +: 32] = 32'(j + 1);
    bus.KS_IN = b; bus.KS_VLD = 1'b1;
    tick();
    bus.KS_VLD = 1'b0;
    bus.DIN = 32'hFFFF_FFFF; bus.DIN_VLD = 1'b1; bus.DOUT_RDY = 1'b1;
    for (int i = 0; i < UNROLL; i++) begin
      tick();
      exp = 32'hFFFF_FFFF ^ 32'(i + 1);
      checks++;
      if (bus.DOUT_VLD !== 1'b1 || bus.DOUT !== exp) begin
        failures++; $display("FAIL xor_order[%0d] got=%h/%b exp=%h/1", i, bus.DOUT, bus.DOUT_VLD, exp);
      end
    end
    bus.DIN_VLD = 1'b0;
    #1;
    checks++; if (bus.DIN_RDY !== 1'b0) begin failures++; $display("FAIL xor_din_rdy got=%b exp=0", bus.DIN_RDY); end
    checks++; if (bus.LEVEL !== LW'(0)) begin failures++; $display("FAIL xor_level got=%0d exp=0", bus.LEVEL); end
    checks++; if (bus.WCNT !== 16'd9) begin failures++; $display("FAIL xor_wcnt got=%0d exp=9", bus.WCNT); end
  endtask

  task automatic test_full();
    logic [WW-1:0] beats[5];
    logic [31:0]   din, exp;
    for (int k = 0; k < 5; k++) beats[k] = rand_beat();
    bus.DIN_VLD = 1'b0; bus.DOUT_RDY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.KS_IN = beats[k]; bus.KS_VLD = 1'b1;
      tick();
    end
    checks++; if (bus.KS_RDY !== 1'b0) begin failures++; $display("FAIL full_ks_rdy got=%b exp=0", bus.KS_RDY); end
    checks++; if (bus.LEVEL !== LW'(4)) begin failures++; $display("FAIL full_level got=%0d exp=4", bus.LEVEL); end
    bus.KS_IN = beats[4];
    tick(); tick();
    checks++; if (bus.LEVEL !== LW'(4)) begin failures++; $display("FAIL full_held got=%0d exp=4", bus.LEVEL); end
    bus.DIN_VLD = 1'b1;
    for (int i = 0; i < UNROLL; i++) begin
      din = $urandom; bus.DIN = din;
      tick();
      exp = din ^ word_of(beats[0], i);
      checks++; if (bus.DOUT !== exp) begin failures++; $display("FAIL full_first[%0d] got=%h exp=%h", i, bus.DOUT, exp); end
    end
    checks++; if (bus.KS_RDY !== 1'b1) begin failures++; $display("FAIL full_ks_rdy_after_pop got=%b exp=1", bus.KS_RDY); end
    checks++; if (bus.LEVEL !== LW'(3)) begin failures++; $display("FAIL full_level_after_pop got=%0d exp=3", bus.LEVEL); end
    bus.DIN_VLD = 1'b0;
    tick();
    bus.KS_VLD = 1'b0;
    checks++; if (bus.LEVEL !== LW'(4)) begin failures++; $display("FAIL full_fifth_push got=%0d exp=4", bus.LEVEL); end
    bus.DIN_VLD = 1'b1;
    for (int i = 0; i < 4 * UNROLL; i++) begin
      din = $urandom; bus.DIN = din;
      tick();
      exp = din ^ word_of(beats[1 + i / UNROLL], i % UNROLL);
      checks++; if (bus.DOUT !== exp) begin failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, bus.DOUT, exp); end
    end
    bus.DIN_VLD = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    clr = 1'b1; tick(); clr = 1'b0;
    m_hs = 0;
    for (int k = 0; k < 2; k++) begin
      bus.KS_IN = rand_beat(); bus.KS_VLD = 1'b1;
      tick();
    end
    bus.KS_VLD = 1'b0; bus.DIN_VLD = 1'b1; bus.DOUT_RDY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.DIN = $urandom; tick();
      checks++; if (bus.DOUT !== m_dout) begin failures++; $display("FAIL bp_pre[%0d] got=%h exp=%h", i, bus.DOUT, m_dout); end
    end
    bus.DOUT_RDY = 1'b0;
    held = m_dout;
    for (int i = 0; i < 5; i++) begin
      bus.DIN = $urandom;
      #1;
      checks++; if (bus.DIN_RDY !== 1'b0) begin failures++; $display("FAIL bp_din_rdy[%0d] got=%b exp=0", i, bus.DIN_RDY); end
      tick();
      checks++;
      if (bus.DOUT !== held || bus.DOUT_VLD !== 1'b1) begin
        failures++; $display("FAIL bp_hold[%0d] got=%h/%b exp=%h/1", i, bus.DOUT, bus.DOUT_VLD, held);
      end
    end
    bus.DOUT_RDY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.DIN = $urandom; tick();
      checks++; if (bus.DOUT !== m_dout) begin failures++; $display("FAIL bp_post[%0d] got=%h exp=%h", i, bus.DOUT, m_dout); end
    end
    bus.DIN_VLD = 1'b0;
    checks++;
    if (bus.WCNT !== 16'(m_hs + int'(m_vld))) begin
      failures++; $display("FAIL bp_wcnt got=%0d exp=%0d", bus.WCNT, m_hs + int'(m_vld));
    end
  endtask

  task automatic test_clr();
    logic [31:0] dsave;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.KS_IN = rand_beat(); bus.KS_VLD = 1'b1;
      tick();
    end
    bus.KS_VLD = 1'b0; bus.DIN_VLD = 1'b1; bus.DOUT_RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin bus.DIN = $urandom; tick(); end
    checks++; if (bus.LEVEL !== LW'(2) || bus.WCNT !== 16'd4) begin failures++; $display("FAIL clr_setup got=%0d/%0d exp=2/4", bus.LEVEL, bus.WCNT); end
    dsave = m_dout;
    clr = 1'b1; bus.KS_IN = rand_beat(); bus.KS_VLD = 1'b1; bus.DIN = $urandom;
    tick();
    clr = 1'b0; bus.KS_VLD = 1'b0; bus.DIN_VLD = 1'b0;
    #1;
    checks++; if (bus.LEVEL !== LW'(0)) begin failures++; $display("FAIL clr_level got=%0d exp=0", bus.LEVEL); end
    checks++; if (bus.DOUT_VLD !== 1'b0) begin failures++; $display("FAIL clr_dout_vld got=%b exp=0", bus.DOUT_VLD); end
    checks++; if (bus.WCNT !== 16'h0) begin failures++; $display("FAIL clr_wcnt got=%0d exp=0", bus.WCNT); end
    checks++; if (bus.DIN_RDY !== 1'b0) begin failures++; $display("FAIL clr_din_rdy got=%b exp=0", bus.DIN_RDY); end
    checks++; if (bus.KS_RDY !== 1'b1) begin failures++; $display("FAIL clr_ks_rdy got=%b exp=1", bus.KS_RDY); end
    checks++; if (bus.DOUT !== dsave) begin failures++; $display("FAIL clr_dout_keep got=%h exp=%h", bus.DOUT, dsave); end
  endtask

  task automatic test_reset_mid();
    logic [WW-1:0] nb;
    logic [31:0]   din, exp;
    bus.DIN_VLD = 1'b0; bus.DOUT_RDY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.KS_IN = rand_beat(); bus.KS_VLD = 1'b1;
      tick();
    end
    bus.KS_VLD = 1'b0; bus.DIN_VLD = 1'b1; bus.DOUT_RDY = 1'b0; bus.DIN = $urandom;
    tick();
    checks++; if (bus.LEVEL !== LW'(3) || bus.DOUT_VLD !== 1'b1) begin failures++; $display("FAIL rmid_setup got=%0d/%b exp=3/1", bus.LEVEL, bus.DOUT_VLD); end
    rstn = 1'b0;
    tick();
    checks++;
    if (bus.DOUT !== 32'h0 || bus.DOUT_VLD !== 1'b0 || bus.WCNT !== 16'h0 || bus.LEVEL !== LW'(0)
        || bus.KS_RDY !== 1'b1 || bus.DIN_RDY !== 1'b0) begin
      failures++;
      $display("FAIL rmid_outputs got dout=%h vld=%b wcnt=%0d lvl=%0d ksr=%b dr=%b exp 0/0/0/0/1/0",
               bus.DOUT, bus.DOUT_VLD, bus.WCNT, bus.LEVEL, bus.KS_RDY, bus.DIN_RDY);
    end
    rstn = 1'b1; bus.DIN_VLD = 1'b0; bus.DOUT_RDY = 1'b1;
    nb = rand_beat(); bus.KS_IN = nb; bus.KS_VLD = 1'b1;
    tick();
    bus.KS_VLD = 1'b0; din = $urandom; bus.DIN = din; bus.DIN_VLD = 1'b1;
    tick();
    bus.DIN_VLD = 1'b0;
    exp = din ^ word_of(nb, 0);
    checks++; if (bus.DOUT !== exp) begin failures++; $display("FAIL rmid_first_word got=%h exp=%h", bus.DOUT, exp); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.KS_VLD   = 1'($urandom_range(0, 1));
      bus.KS_IN    = rand_beat();
      bus.DIN_VLD  = 1'($urandom_range(0, 1));
      bus.DIN      = $urandom;
      bus.DOUT_RDY = ($urandom_range(0, 3) != 0);
      clr          = ($urandom_range(0, 63) == 0);
      #1;
      checks++;
      if (bus.KS_RDY !== f_ks_rdy() || bus.DIN_RDY !== f_din_rdy()) begin
        failures++; $display("FAIL rand_rdy[%0d] got=%b/%b exp=%b/%b", i, bus.KS_RDY, bus.DIN_RDY, f_ks_rdy(), f_din_rdy());
      end
      tick();
      checks++;
      if (bus.DOUT !== m_dout || bus.DOUT_VLD !== m_vld || bus.LEVEL !== LW'(f_level()) || bus.WCNT !== m_wcnt) begin
        failures++;
        $display("FAIL rand_state[%0d] got=%h/%b/%0d/%0d exp=%h/%b/%0d/%0d", i, bus.DOUT, bus.DOUT_VLD, bus.LEVEL,
                 bus.WCNT, m_dout, m_vld, f_level(), m_wcnt);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_xor_order();
    test_full();
    test_backpressure();
    test_clr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keystream_xor.md
KEYSTREAM_XOR -- requirements
Module: keystream_xor

Interface
REQ-001 The block SHALL have parameter UNROLL, default 9, giving the number of 32-bit keystream words per keystream-bus beat.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of keystream-beat entries in the internal FIFO; DEPTH SHALL be 2 or more.
REQ-003 The block SHALL have port CLK, input, 1 bit: clock, all state updated on the rising edge.
REQ-004 The block SHALL have port RSTn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port CLR, input, 1 bit: synchronous session flush.
REQ-006 The block SHALL have port KS_IN, input, 32*UNROLL bits: keystream beat; word 0 occupies bits [32*UNROLL-1:32*(UNROLL-1)] and word UNROLL-1 occupies bits [31:0].
REQ-007 The block SHALL have port KS_VLD, input, 1 bit: KS_IN holds a valid beat.
REQ-008 The block SHALL have port KS_RDY, output, 1 bit: FIFO can accept a beat; this output drives the generator enable, and the generator holds its beat while KS_RDY is 0.
REQ-009 The block SHALL have port DIN, input, 32 bits: plaintext or ciphertext word.
REQ-010 The block SHALL have port DIN_VLD, input, 1 bit: DIN is valid.
REQ-011 The block SHALL have port DIN_RDY, output, 1 bit: DIN is accepted this cycle.
REQ-012 The block SHALL have port DOUT, output, 32 bits: DIN XOR keystream word.
REQ-013 The block SHALL have port DOUT_VLD, output, 1 bit: DOUT is valid.
REQ-014 The block SHALL have port DOUT_RDY, input, 1 bit: the sink accepts DOUT.
REQ-015 The block SHALL have port LEVEL, output, clog2(DEPTH+1) bits: number of occupied FIFO entries.
REQ-016 The block SHALL have port WCNT, output, 16 bits: count of words processed since reset or CLR.

Function
REQ-017 The FIFO SHALL accept (push) a beat on a cycle where KS_VLD=1 and KS_RDY=1.
REQ-018 KS_RDY SHALL equal (LEVEL != DEPTH) and SHALL be derived from registered state only.
- A pop in the same cycle SHALL NOT raise KS_RDY in that cycle.
REQ-019 The block SHALL keep a word index IDX (0..UNROLL-1) that selects the current keystream word from the head entry, taking word 0 first.
REQ-020 DIN_RDY SHALL equal (LEVEL != 0) AND (DOUT_VLD=0 OR DOUT_RDY=1).
REQ-021 A fire SHALL occur on a cycle where DIN_VLD=1 and DIN_RDY=1.
- On a fire: DOUT <= DIN ^ head word[IDX], DOUT_VLD <= 1, and WCNT increments, wrapping from 0xFFFF to 0.
REQ-022 The latency from a DIN handshake to DOUT_VLD SHALL be exactly 1 cycle.
- Throughput SHALL be 1 word per cycle while the FIFO is non-empty and the sink is ready.
REQ-023 On a fire with IDX=UNROLL-1, the block SHALL pop the head entry, set IDX <= 0, and decrement LEVEL, unless a push occurs in the same cycle, in which case LEVEL is unchanged.
REQ-024 On a fire with IDX<UNROLL-1, the block SHALL increment IDX and SHALL NOT pop.
REQ-025 When DOUT_VLD=1 and DOUT_RDY=1 and no fire occurs, the block SHALL clear DOUT_VLD; DOUT SHALL hold its value.
REQ-026 When DOUT_VLD=1 and DOUT_RDY=0, DOUT and DOUT_VLD SHALL hold, and no fire SHALL occur.
REQ-027 An empty FIFO SHALL force DIN_RDY=0; DIN words SHALL never be XORed with an absent or stale keystream.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; entries SHALL be popped in push order with no loss or duplication.
REQ-029 CLR=1 SHALL, on the next edge, empty the FIFO and set LEVEL=0, IDX=0, DOUT_VLD=0, and WCNT=0.
- CLR SHALL override any push or fire in the same cycle.
- DOUT SHALL retain its value.

Reset
REQ-030 RSTn=0 SHALL take priority over CLR and all other inputs.
REQ-031 While RSTn=0, the outputs SHALL be: DOUT=0, DOUT_VLD=0, WCNT=0, LEVEL=0, KS_RDY=1, DIN_RDY=0; FIFO pointers and IDX SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered keystream and any pending DOUT within one edge.

Verification
REQ-033 Reset: hold RSTn=0 for 2 cycles -> DOUT=0, DOUT_VLD=0, DIN_RDY=0, KS_RDY=1, LEVEL=0, WCNT=0.
REQ-034 XOR order (UNROLL=9): push one beat with words 0x00000001..0x00000009 (word 0 first), then apply DIN=0xFFFFFFFF for 9 cycles with DOUT_RDY=1 -> DOUT=0xFFFFFFFE, 0xFFFFFFFD, ... 0xFFFFFFF6, each 1 cycle after its DIN; then DIN_RDY=0, LEVEL=0, WCNT=9.
REQ-035 Full (DEPTH=4): push 4 beats with DIN_VLD=0 -> KS_RDY=0 and LEVEL=4 after the 4th edge; the 5th beat is held. Consume 9 words -> KS_RDY=1 on the cycle after the pop, and the 5th beat is accepted intact.
REQ-036 Backpressure: with DOUT_VLD=1, set DOUT_RDY=0 for 5 cycles -> DOUT stable and DIN_RDY=0. Release -> the stream continues with no lost or duplicated words (WCNT matches the DOUT handshake count).
REQ-037 CLR mid-entry: at IDX=4, LEVEL=2, pulse CLR together with KS_VLD=1 and DIN_VLD=1 -> next cycle LEVEL=0, DOUT_VLD=0, WCNT=0, DIN_RDY=0, KS_RDY=1, and no push occurred.
REQ-038 Reset mid-burst: assert RSTn=0 while LEVEL=3 and DOUT_VLD=1 -> all values in REQ-031 hold after one edge; the first word after release uses word 0 of the next pushed beat.
